// File: rtl/alu_sequencer.sv
// Command sequencer for the 8-bit breadboard ALU: owns the accumulator, B register
// and flags, runs LDA/ADD/SUB/OUT one at a time, and presents acc on an output handshake.
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_subtract,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic [WIDTH-1:0] acc,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    OUT_WAIT
  } state_t;

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] b_reg, b_nxt;
  logic [1:0]       op_reg, op_nxt;
  logic [WIDTH-1:0] acc_nxt, out_data_nxt;
  logic             carry_nxt, zero_nxt, out_valid_nxt, done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      b_reg      <= '0;
      op_reg     <= OP_LDA;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      b_reg      <= b_nxt;
      op_reg     <= op_nxt;
      carry_flag <= carry_nxt;
      zero_flag  <= zero_nxt;
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      done       <= done_nxt;
    end
  end

  // done is a registered pulse, so it lines up with the cycle the new acc
  // or the dropped out_valid first becomes visible.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    b_nxt         = b_reg;
    op_nxt        = op_reg;
    carry_nxt     = carry_flag;
    zero_nxt      = zero_flag;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LDA: begin
              acc_nxt   = cmd_data;
              zero_nxt  = (cmd_data == '0);
              carry_nxt = 1'b0;
              done_nxt  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              b_nxt     = cmd_data;
              op_nxt    = cmd_op;
              state_nxt = EXEC;
            end
            OP_OUT: begin
              out_data_nxt  = acc;
              out_valid_nxt = 1'b1;
              state_nxt     = OUT_WAIT;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
      EXEC: begin
        acc_nxt   = alu_out;
        carry_nxt = alu_carry;
        zero_nxt  = (alu_out == '0);
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      OUT_WAIT: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          done_nxt      = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready    = (state == IDLE);
  assign alu_a        = acc;
  assign alu_b        = b_reg;
  assign alu_subtract = (state == EXEC) && (op_reg == OP_SUB);

endmodule
